// File: rtl/ws2812_rx.sv
// WS2812 single-wire stream decoder: pulse-width bit slicer, 24-bit pixel assembly, frame gap and error flags.
// Optional passthrough output for chained receivers is enabled with `define WS2812_RX_PASSTHRU_EN.
module ws2812_rx #(
    parameter int T_THRESH     = 7,
    parameter int MIN_HIGH     = 2,
    parameter int MAX_HIGH     = 24,
    parameter int RESET_CYCLES = 600
) (
    input  logic        hwclk,
    input  logic        reset,
    input  logic        ws_din,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        data_valid,
    output logic        frame_done,
    output logic        bit_err,
    output logic        ws_dout
);

    localparam logic [1:0] WAIT_GAP = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] HIGH     = 2'd2;
    localparam logic [1:0] LOW      = 2'd3;

    logic        sync1_q, sync1_d, sync2_q, sync2_d, line_q, line_d;
    logic        rise_q, rise_d, fall_q, fall_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [22:0] shift_q, shift_d;
    logic [7:0]  pix_q, pix_d, led_q, led_d;
    logic [23:0] rgb_q, rgb_d;
    logic        active_q, active_d;
    logic        valid_q, valid_d, done_q, done_d, err_q, err_d;
    logic [15:0] hcnt_inc, lcnt_inc;
    logic        bit_val;

    // Edge pulses are registered alongside the delayed level so both describe the same sample.
    always_comb begin
        sync1_d = ws_din;
        sync2_d = sync1_q;
        line_d  = sync2_q;
        rise_d  = sync2_q & ~line_q;
        fall_d  = ~sync2_q & line_q;
    end

    always_comb begin
        hcnt_inc   = (hcnt_q == 16'hFFFF) ? hcnt_q : hcnt_q + 16'd1;
        lcnt_inc   = (lcnt_q == 16'hFFFF) ? lcnt_q : lcnt_q + 16'd1;
        bit_val    = (hcnt_q >= 16'(T_THRESH));
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        lcnt_d     = lcnt_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        pix_d      = pix_q;
        led_d      = led_q;
        rgb_d      = rgb_q;
        active_d   = active_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            WAIT_GAP: begin
                if (lcnt_q >= 16'(RESET_CYCLES)) state_d = IDLE;
                else if (line_q)                 lcnt_d  = 16'd0;
                else                             lcnt_d  = lcnt_inc;
            end
            IDLE: begin
                if (rise_q) begin
                    state_d = HIGH;
                    hcnt_d  = 16'd1;
                end
            end
            HIGH: begin
                if (hcnt_q > 16'(MAX_HIGH)) begin
                    err_d    = 1'b1;
                    bitcnt_d = 5'd0;
                    lcnt_d   = 16'd0;
                    pix_d    = 8'd0;
                    active_d = 1'b0;
                    state_d  = WAIT_GAP;
                end else if (fall_q) begin
                    // A glitch before any real bit of the frame must not start a frame gap count.
                    if (hcnt_q < 16'(MIN_HIGH)) begin
                        state_d = active_q ? LOW : IDLE;
                    end else begin
                        shift_d  = {shift_q[21:0], bit_val};
                        active_d = 1'b1;
                        lcnt_d   = 16'd1;
                        state_d  = LOW;
                        if (bitcnt_q == 5'd23) begin
                            rgb_d    = {shift_q, bit_val};
                            led_d    = pix_q;
                            valid_d  = 1'b1;
                            pix_d    = (pix_q == 8'hFF) ? pix_q : pix_q + 8'd1;
                            bitcnt_d = 5'd0;
                        end else begin
                            bitcnt_d = bitcnt_q + 5'd1;
                        end
                    end
                end else begin
                    hcnt_d = hcnt_inc;
                end
            end
            default: begin
                if (lcnt_q >= 16'(RESET_CYCLES)) begin
                    done_d   = 1'b1;
                    err_d    = (bitcnt_q != 5'd0);
                    bitcnt_d = 5'd0;
                    pix_d    = 8'd0;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else if (rise_q) begin
                    state_d = HIGH;
                    hcnt_d  = 16'd1;
                end else begin
                    lcnt_d = lcnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            line_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            state_q  <= WAIT_GAP;
            hcnt_q   <= 16'd0;
            lcnt_q   <= 16'd0;
            bitcnt_q <= 5'd0;
            shift_q  <= 23'd0;
            pix_q    <= 8'd0;
            led_q    <= 8'd0;
            rgb_q    <= 24'd0;
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            line_q   <= line_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            lcnt_q   <= lcnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            pix_q    <= pix_d;
            led_q    <= led_d;
            rgb_q    <= rgb_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign rgb_data   = rgb_q;
    assign led_num    = led_q;
    assign data_valid = valid_q;
    assign frame_done = done_q;
    assign bit_err    = err_q;

`ifdef WS2812_RX_PASSTHRU_EN
    logic pass_q, pass_d, dout_q, dout_d;

    // Forwarding opens once this receiver has consumed its own pixel and closes at any gap or error.
    always_comb begin
        if (state_d == WAIT_GAP || state_d == IDLE) pass_d = 1'b0;
        else if (valid_d)                           pass_d = 1'b1;
        else                                        pass_d = pass_q;
        dout_d = pass_q & line_q;
    end

    always_ff @(posedge hwclk) begin
        if (!reset) begin
            pass_q <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
            dout_q <= dout_d;
        end
    end

    assign ws_dout = dout_q;
`else
    assign ws_dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: frames, pixel indexing, glitches, protocol errors, reset and passthrough.
module tb_ws2812_rx;
    logic        hwclk = 1'b0;
    logic        reset = 1'b0;
    logic        ws_din = 1'b0;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        data_valid, frame_done, bit_err, ws_dout;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_low_cyc = 0;

    logic [23:0] val_rgb[$];
    logic [7:0]  val_led[$];
    int          val_cyc[$];
    int          done_cnt = 0, err_cnt = 0, coinc_cnt = 0, dout_hi_cnt = 0;
    logic        din_hist[0:32767];
    logic        dout_hist[0:32767];

    ws2812_rx dut (
        .hwclk(hwclk), .reset(reset), .ws_din(ws_din),
        .rgb_data(rgb_data), .led_num(led_num), .data_valid(data_valid),
        .frame_done(frame_done), .bit_err(bit_err), .ws_dout(ws_dout)
    );

    always #5 hwclk = ~hwclk;
    always @(posedge hwclk) cyc <= cyc + 1;

    always @(negedge hwclk) begin
        dout_hist[cyc & 32767] = ws_dout;
        if (ws_dout) dout_hi_cnt = dout_hi_cnt + 1;
        if (reset) begin
            if (data_valid) begin
                val_rgb.push_back(rgb_data);
                val_led.push_back(led_num);
                val_cyc.push_back(cyc);
            end
            if (frame_done) done_cnt = done_cnt + 1;
            if (bit_err) err_cnt = err_cnt + 1;
            if (frame_done && bit_err) coinc_cnt = coinc_cnt + 1;
        end
    end

    task automatic tick(input logic b);
        @(negedge hwclk);
        ws_din = b;
        din_hist[cyc & 32767] = b;
    endtask

    task automatic send_bit(input logic b);
        for (int i = 0; i < (b ? 8 : 4); i++) tick(1'b1);
        tick(1'b0);
        last_low_cyc = cyc;
        for (int i = 1; i < (b ? 7 : 11); i++) tick(1'b0);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic clear_mon();
        val_rgb.delete();
        val_led.delete();
        val_cyc.delete();
        done_cnt = 0;
        err_cnt = 0;
        coinc_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge hwclk);
        vectors += 6;
        if (rgb_data !== 24'd0) begin miscompares++; $display("[TB] FAIL reset_rgb got %h want 000000", rgb_data); end
        if (led_num !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_led got %0d want 0", led_num); end
        if (data_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", data_valid); end
        if (frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", frame_done); end
        if (bit_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got %b want 0", bit_err); end
        if (ws_dout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dout got %b want 0", ws_dout); end
        reset = 1'b1;
    endtask

    task automatic test_single_pixel();
        clear_mon();
        hold_low(700);
        send_word(24'h101010);
        hold_low(700);
        vectors += 6;
        if (val_rgb.size() !== 1) begin
            miscompares++; $display("[TB] FAIL single_count got %0d want 1", val_rgb.size());
        end else begin
            if (val_rgb[0] !== 24'h101010) begin miscompares++; $display("[TB] FAIL single_rgb got %h want 101010", val_rgb[0]); end
            if (val_led[0] !== 8'd0) begin miscompares++; $display("[TB] FAIL single_led got %0d want 0", val_led[0]); end
            if (val_cyc[0] - last_low_cyc !== 4) begin miscompares++; $display("[TB] FAIL single_latency got %0d want 4", val_cyc[0] - last_low_cyc); end
        end
        if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL single_done got %0d want 1", done_cnt); end
        if (err_cnt !== 0) begin miscompares++; $display("[TB] FAIL single_err got %0d want 0", err_cnt); end
    endtask

    task automatic test_multi_pixel();
        logic [23:0] exp_rgb[5];
        logic [7:0]  exp_led[5];
        exp_rgb = '{24'h101010, 24'h000000, 24'h101010, 24'h000000, 24'h00FF00};
        exp_led = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        clear_mon();
        send_word(24'h101010);
        send_word(24'h000000);
        send_word(24'h101010);
        send_word(24'h000000);
        hold_low(700);
        send_word(24'h00FF00);
        hold_low(700);
        vectors += 2;
        if (done_cnt !== 2) begin miscompares++; $display("[TB] FAIL multi_done got %0d want 2", done_cnt); end
        if (val_rgb.size() !== 5) begin
            miscompares++; $display("[TB] FAIL multi_count got %0d want 5", val_rgb.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors += 2;
                if (val_rgb[i] !== exp_rgb[i]) begin miscompares++; $display("[TB] FAIL multi_rgb%0d got %h want %h", i, val_rgb[i], exp_rgb[i]); end
                if (val_led[i] !== exp_led[i]) begin miscompares++; $display("[TB] FAIL multi_led%0d got %0d want %0d", i, val_led[i], exp_led[i]); end
            end
        end
    endtask

    task automatic test_partial_word();
        logic [23:0] w;
        clear_mon();
        w = 24'hABCDEF;
        for (int i = 23; i >= 12; i--) send_bit(w[i]);
        hold_low(700);
        vectors += 4;
        if (val_rgb.size() !== 0) begin miscompares++; $display("[TB] FAIL partial_valid got %0d want 0", val_rgb.size()); end
        if (coinc_cnt !== 1) begin miscompares++; $display("[TB] FAIL partial_coincide got %0d want 1", coinc_cnt); end
        if (err_cnt !== 1) begin miscompares++; $display("[TB] FAIL partial_err got %0d want 1", err_cnt); end
        if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL partial_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_glitch();
        logic [23:0] w;
        clear_mon();
        w = 24'hC33C81;
        for (int i = 23; i >= 0; i--) begin
            if (i == 8) begin
                for (int k = 0; k < 4; k++) tick(1'b1);
                for (int k = 0; k < 5; k++) tick(1'b0);
                tick(1'b1);
                for (int k = 0; k < 5; k++) tick(1'b0);
            end else begin
                send_bit(w[i]);
            end
        end
        hold_low(700);
        vectors += 3;
        if (err_cnt !== 0) begin miscompares++; $display("[TB] FAIL glitch_err got %0d want 0", err_cnt); end
        if (val_rgb.size() !== 1) begin
            miscompares++; $display("[TB] FAIL glitch_count got %0d want 1", val_rgb.size());
        end else if (val_rgb[0] !== 24'hC33C81) begin
            miscompares++; $display("[TB] FAIL glitch_rgb got %h want c33c81", val_rgb[0]);
        end
        if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL glitch_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_long_high();
        clear_mon();
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        for (int i = 0; i < 30; i++) tick(1'b1);
        tick(1'b0);
        for (int i = 0; i < 19; i++) send_bit(1'b1);
        vectors += 2;
        if (err_cnt !== 1) begin miscompares++; $display("[TB] FAIL long_err got %0d want 1", err_cnt); end
        if (val_rgb.size() !== 0) begin miscompares++; $display("[TB] FAIL long_ignored got %0d want 0", val_rgb.size()); end
        hold_low(700);
        send_word(24'hA5A5A5);
        hold_low(700);
        vectors += 1;
        if (val_rgb.size() !== 1) begin
            miscompares++; $display("[TB] FAIL long_count got %0d want 1", val_rgb.size());
        end else if (val_rgb[0] !== 24'hA5A5A5) begin
            miscompares++; $display("[TB] FAIL long_rgb got %h want a5a5a5", val_rgb[0]);
        end
    endtask

    task automatic test_reset_midword();
        clear_mon();
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        @(negedge hwclk);
        reset = 1'b0;
        @(negedge hwclk);
        vectors += 2;
        if (rgb_data !== 24'd0) begin miscompares++; $display("[TB] FAIL midreset_rgb got %h want 000000", rgb_data); end
        if (led_num !== 8'd0) begin miscompares++; $display("[TB] FAIL midreset_led got %0d want 0", led_num); end
        reset = 1'b1;
        for (int i = 0; i < 14; i++) send_bit(1'b1);
        hold_low(700);
        send_word(24'h3C5A96);
        hold_low(700);
        vectors += 2;
        if (val_rgb.size() !== 1) begin
            miscompares++; $display("[TB] FAIL midreset_count got %0d want 1", val_rgb.size());
        end else begin
            vectors += 1;
            if (val_rgb[0] !== 24'h3C5A96) begin miscompares++; $display("[TB] FAIL midreset_rgb2 got %h want 3c5a96", val_rgb[0]); end
            if (val_led[0] !== 8'd0) begin miscompares++; $display("[TB] FAIL midreset_led2 got %0d want 0", val_led[0]); end
        end
        if (err_cnt !== 0) begin miscompares++; $display("[TB] FAIL midreset_err got %0d want 0", err_cnt); end
    endtask

    task automatic test_passthru();
        int p0, p1, pend, bad0, bad1;
        clear_mon();
        dout_hi_cnt = 0;
        p0 = cyc;
        send_word(24'h123456);
        p1 = cyc + 1;
        send_word(24'hF0A55A);
        send_word(24'h0F0F0F);
        pend = cyc;
        hold_low(700);
        bad0 = 0;
        bad1 = 0;
        for (int c = p0; c < p1; c++) if (dout_hist[c & 32767] !== 1'b0) bad0++;
        for (int c = p1; c <= pend; c++) if (dout_hist[c & 32767] !== din_hist[(c - 4) & 32767]) bad1++;
        vectors += 1;
        if (val_rgb.size() !== 3) begin miscompares++; $display("[TB] FAIL pass_count got %0d want 3", val_rgb.size()); end
`ifdef WS2812_RX_PASSTHRU_EN
        vectors += 2;
        if (bad0 !== 0) begin miscompares++; $display("[TB] FAIL pass_pixel0 got %0d high cycles want 0", bad0); end
        if (bad1 !== 0) begin miscompares++; $display("[TB] FAIL pass_forward got %0d wrong cycles want 0", bad1); end
`else
        vectors += 2;
        if (bad0 !== 0) begin miscompares++; $display("[TB] FAIL nopass_pixel0 got %0d high cycles want 0", bad0); end
        if (dout_hi_cnt !== 0) begin miscompares++; $display("[TB] FAIL nopass_dout got %0d high cycles want 0", dout_hi_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_multi_pixel();
        test_partial_word();
        test_glitch();
        test_long_high();
        test_reset_midword();
        test_passthru();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
